ucsbece154b_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch port (I) and the data load/store port (D) of the pipelined RISC-V core.
- Registered three-state FSM (IDLE / BUSY_I / BUSY_D) with a variable-latency memory handshake.
- D has priority by default; a starvation counter bounds how long fetch can be locked out.
- Mispredict flush squashes an in-flight fetch response without aborting the memory access.

---
 rtl/ucsbece154b_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (I) and data (D).
// D wins by default; a starvation counter eventually forces an I grant.
module ucsbece154b_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STARVE = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [3:0] MAX_STARVE_C = 4'(MAX_STARVE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [3:0]        starve_r, starve_s;
   logic              drop_r, drop_s;
   logic              i_elig_s, d_elig_s, grant_i_s;
   logic              mem_req_s, mem_we_s, i_valid_s, d_valid_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_s, i_rdata_s, d_rdata_s;

   // Next-state, arbitration and next-output logic.
   always_comb begin
      state_s     = state_r;
      starve_s    = starve_r;
      drop_s      = drop_r;
      mem_req_s   = mem_req;
      mem_we_s    = mem_we;
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
      i_rdata_s   = i_rdata;
      d_rdata_s   = d_rdata;
      i_valid_s   = 1'b0;
      d_valid_s   = 1'b0;
      // A requester sitting in its own valid cycle must not be granted a second time.
      i_elig_s    = i_req & ~i_valid & ~i_flush;
      d_elig_s    = d_req & ~d_valid;
      grant_i_s   = i_elig_s & (~d_elig_s | (starve_r == MAX_STARVE_C));

      case (state_r)
         IDLE: begin
            drop_s = 1'b0;
            if (grant_i_s) begin
               state_s    = BUSY_I;
               mem_req_s  = 1'b1;
               mem_we_s   = 1'b0;
               mem_addr_s = i_addr;
               starve_s   = 4'd0;
            end else if (d_elig_s) begin
               state_s     = BUSY_D;
               mem_req_s   = 1'b1;
               mem_we_s    = d_we;
               mem_addr_s  = d_addr;
               mem_wdata_s = d_wdata;
               if (i_elig_s) begin
                  starve_s = (starve_r == MAX_STARVE_C) ? starve_r : starve_r + 4'd1;
               end else if (!i_req) begin
                  starve_s = 4'd0;
               end else begin
                  starve_s = starve_r;
               end
            end else if (!i_req) begin
               starve_s = 4'd0;
            end else begin
               starve_s = starve_r;
            end
         end
         BUSY_I: begin
            if (i_flush) begin
               drop_s = 1'b1;
            end else begin
               drop_s = drop_r;
            end
            // The squashed access still runs to completion; only the response is discarded.
            if (mem_ready) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
               drop_s    = 1'b0;
               if (!(drop_r || i_flush)) begin
                  i_valid_s = 1'b1;
                  i_rdata_s = mem_rdata;
               end else begin
                  i_valid_s = 1'b0;
               end
            end else begin
               state_s = BUSY_I;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
               d_valid_s = 1'b1;
               d_rdata_s = mem_rdata;
            end else begin
               state_s = BUSY_D;
            end
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
            drop_s    = 1'b0;
         end
      endcase
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         starve_r  <= 4'd0;
         drop_r    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_valid   <= 1'b0;
         d_valid   <= 1'b0;
      end else begin
         state_r   <= state_s;
         starve_r  <= starve_s;
         drop_r    <= drop_s;
         mem_req   <= mem_req_s;
         mem_we    <= mem_we_s;
         mem_addr  <= mem_addr_s;
         mem_wdata <= mem_wdata_s;
         i_rdata   <= i_rdata_s;
         d_rdata   <= d_rdata_s;
         i_valid   <= i_valid_s;
         d_valid   <= d_valid_s;
      end
   end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed self-checking bench for ucsbece154b_mem_arbiter (MAX_STARVE = 3).
module tb_ucsbece154b_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req, i_flush, i_valid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int cmp_count = 0;
   int err_count = 0;

   ucsbece154b_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(3)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Outputs are sampled and inputs are driven 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_req = 1'b1; i_addr = 32'hFFFF_FFFC; i_flush = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0F00; d_wdata = 32'hFFFF_FFFF;
      mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
      for (int c = 0; c < 3; c++) begin
         tick();
         cmp_count++;
         if ({mem_req, mem_we, i_valid, d_valid} !== 4'b0000) begin
            err_count++;
            $display("FAIL reset_ctrl: got req/we/iv/dv=%b expected 0000", {mem_req, mem_we, i_valid, d_valid});
         end
         cmp_count++;
         if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'd0) begin
            err_count++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, i_rdata, d_rdata);
         end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      mem_ready = 1'b1; mem_rdata = 32'h00A0_0513;
      i_req = 1'b1; i_addr = 32'h0000_0010;
      tick();
      cmp_count++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0010}) begin
         err_count++;
         $display("FAIL fetch_issue: got req=%b we=%b addr=%h expected 1 0 00000010", mem_req, mem_we, mem_addr);
      end
      tick();
      cmp_count++;
      if ({i_valid, i_rdata, mem_req} !== {1'b1, 32'h00A0_0513, 1'b0}) begin
         err_count++;
         $display("FAIL fetch_resp: got iv=%b rdata=%h req=%b expected 1 00a00513 0", i_valid, i_rdata, mem_req);
      end
   endtask

   // i_req is still high during its valid cycle; no second burst may start.
   task automatic test_hold_through_valid();
      tick();
      cmp_count++;
      if ({mem_req, i_valid} !== 2'b00) begin
         err_count++;
         $display("FAIL hold_valid: got req=%b iv=%b expected 0 0", mem_req, i_valid);
      end
      i_req = 1'b0;
      tick();
   endtask

   task automatic test_priority_store();
      mem_ready = 1'b0;
      i_req = 1'b1; i_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
      tick();
      cmp_count++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF}) begin
         err_count++;
         $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000100 deadbeef",
                  mem_req, mem_we, mem_addr, mem_wdata);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         cmp_count++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, d_valid} !== {1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0}) begin
            err_count++;
            $display("FAIL store_stall: got req=%b we=%b addr=%h wdata=%h dv=%b expected held, dv=0",
                     mem_req, mem_we, mem_addr, mem_wdata, d_valid);
         end
      end
      mem_ready = 1'b1; mem_rdata = 32'h0000_0093;
      tick();
      cmp_count++;
      if ({d_valid, mem_req} !== 2'b10) begin
         err_count++;
         $display("FAIL store_done: got dv=%b req=%b expected 1 0", d_valid, mem_req);
      end
      d_req = 1'b0; d_we = 1'b0;
      tick();
      cmp_count++;
      if ({mem_req, mem_we, mem_addr, d_valid} !== {1'b1, 1'b0, 32'h0000_0040, 1'b0}) begin
         err_count++;
         $display("FAIL store_then_fetch: got req=%b we=%b addr=%h dv=%b expected 1 0 00000040 0",
                  mem_req, mem_we, mem_addr, d_valid);
      end
      tick();
      cmp_count++;
      if ({i_valid, i_rdata} !== {1'b1, 32'h0000_0093}) begin
         err_count++;
         $display("FAIL store_fetch_resp: got iv=%b rdata=%h expected 1 00000093", i_valid, i_rdata);
      end
      i_req = 1'b0;
      tick();
   endtask

   // D re-requests every time; i_flush during each d_valid cycle keeps I from
   // sneaking in there, so the counter alone decides when I wins.
   task automatic test_starvation();
      logic [31:0] gaddr [4];
      int   n = 0;
      logic prev_req;
      logic done = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
      i_req = 1'b1; i_addr = 32'h0000_0080;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
      prev_req = mem_req;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (mem_req && !prev_req && n < 4) begin
            gaddr[n] = mem_addr;
            n++;
         end
         prev_req = mem_req;
         i_flush = d_valid;
         if (i_valid) begin
            done = 1'b1;
            i_req = 1'b0; d_req = 1'b0;
         end
      end
      i_flush = 1'b0;
      cmp_count++;
      if (n !== 4 || !done) begin
         err_count++;
         $display("FAIL starve_count: got %0d grants done=%b expected 4 grants then i_valid", n, done);
      end else begin
         cmp_count++;
         if ({gaddr[0], gaddr[1], gaddr[2], gaddr[3]} !== {32'h200, 32'h200, 32'h200, 32'h80}) begin
            err_count++;
            $display("FAIL starve_order: got %h %h %h %h expected 200 200 200 80",
                     gaddr[0], gaddr[1], gaddr[2], gaddr[3]);
         end
      end
      tick();
      // Counter must be back at 0: a fresh simultaneous request goes to D again.
      i_req = 1'b1; i_addr = 32'h0000_0084; d_req = 1'b1;
      tick();
      cmp_count++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0200}) begin
         err_count++;
         $display("FAIL starve_cleared: got req=%b addr=%h expected 1 00000200", mem_req, mem_addr);
      end
      d_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (i_valid) i_req = 1'b0;
      end
   endtask

   task automatic test_flush();
      mem_ready = 1'b0; mem_rdata = 32'h1111_1111;
      i_req = 1'b1; i_addr = 32'h0000_0030;
      tick();
      cmp_count++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0030}) begin
         err_count++;
         $display("FAIL flush_issue: got req=%b addr=%h expected 1 00000030", mem_req, mem_addr);
      end
      tick();
      i_flush = 1'b1; i_addr = 32'h0000_0020;
      tick();
      cmp_count++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0030}) begin
         err_count++;
         $display("FAIL flush_held: got req=%b addr=%h expected 1 00000030", mem_req, mem_addr);
      end
      i_flush = 1'b0; mem_ready = 1'b1;
      tick();
      cmp_count++;
      if ({i_valid, mem_req, i_rdata} !== {1'b0, 1'b0, 32'h1357_9BDF}) begin
         err_count++;
         $display("FAIL flush_drop: got iv=%b req=%b rdata=%h expected 0 0 13579bdf", i_valid, mem_req, i_rdata);
      end
      mem_rdata = 32'h2222_2222;
      tick();
      cmp_count++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0020}) begin
         err_count++;
         $display("FAIL flush_refetch: got req=%b addr=%h expected 1 00000020", mem_req, mem_addr);
      end
      tick();
      cmp_count++;
      if ({i_valid, i_rdata} !== {1'b1, 32'h2222_2222}) begin
         err_count++;
         $display("FAIL flush_refetch_resp: got iv=%b rdata=%h expected 1 22222222", i_valid, i_rdata);
      end
      i_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_dv = 1'b0;
      mem_ready = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
      tick();
      tick();
      reset = 1'b1;
      tick();
      cmp_count++;
      if ({mem_req, d_valid} !== 2'b00) begin
         err_count++;
         $display("FAIL reset_mid: got req=%b dv=%b expected 0 0", mem_req, d_valid);
      end
      reset = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (d_valid || mem_req) saw_dv = 1'b1;
      end
      cmp_count++;
      if (saw_dv !== 1'b0) begin
         err_count++;
         $display("FAIL reset_mid_quiet: got activity=%b expected 0", saw_dv);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_hold_through_valid();
      test_priority_store();
      test_starvation();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
